// File: rtl/cgra_boot_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : cgra_boot_sequencer
// Description : Moore FSM that sequences the power-up of a CGRA subsystem:
//               configuration chain reset, bitstream load, drain, CGRA
//               datapath reset and finally release of the RISC-V core.
//               Also handles run-time reconfiguration (core stays out of
//               reset) and a configuration-load timeout with an ERROR state.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters
//   RESET_CYCLES  cycles each reset phase is held (1..255)
//   DRAIN_CYCLES  idle cycles between configurator disable and CGRA reset
//   CFG_TIMEOUT   max CFG_RUN cycles before ERROR (0 = no timeout)
//   AUTO_START    1 = IDLE behaves as if start_i were held high
// Ports
//   clk_i, rst_ni            clock, synchronous active-low reset
//   start_i                  boot request (IDLE only)
//   reconfig_req_i           reconfiguration request (RUN only)
//   clear_i                  leave ERROR (ERROR only)
//   configurator_done_i      bitstream load finished (CFG_RUN only)
//   config_clock_en_o        configuration clock enable
//   config_reset_o           configuration chain reset (active-high)
//   configurator_reset_o     configurator reset (active-high)
//   configurator_enable_o    configurator run enable
//   cgra_clock_en_o          CGRA datapath clock enable
//   cgra_reset_o             CGRA datapath reset (active-high)
//   core_rst_no              RISC-V core reset (active-low)
//   riscv_enable_o           RISC-V core run enable
//   busy_o, done_o, error_o  status flags
//   state_o                  encoded FSM state
// ============================================================================
module cgra_boot_sequencer #(
    parameter int unsigned RESET_CYCLES = 2,
    parameter int unsigned DRAIN_CYCLES = 1,
    parameter int unsigned CFG_TIMEOUT  = 1000,
    parameter int unsigned AUTO_START   = 0
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       start_i,
    input  logic       reconfig_req_i,
    input  logic       clear_i,
    input  logic       configurator_done_i,
    output logic       config_clock_en_o,
    output logic       config_reset_o,
    output logic       configurator_reset_o,
    output logic       configurator_enable_o,
    output logic       cgra_clock_en_o,
    output logic       cgra_reset_o,
    output logic       core_rst_no,
    output logic       riscv_enable_o,
    output logic       busy_o,
    output logic       done_o,
    output logic       error_o,
    output logic [2:0] state_o
);

    localparam logic [7:0]  RESET_LEN   = 8'(RESET_CYCLES);
    localparam logic [7:0]  DRAIN_LEN   = 8'(DRAIN_CYCLES);
    localparam logic [15:0] TIMEOUT_LEN = 16'(CFG_TIMEOUT);
    localparam logic        AUTO        = (AUTO_START != 0);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_CFG_RST   = 3'd1,
        S_CFG_RUN   = 3'd2,
        S_CFG_DRAIN = 3'd3,
        S_CGRA_RST  = 3'd4,
        S_RUN       = 3'd5,
        S_ERROR     = 3'd6
    } state_t;

    state_t      state;
    state_t      state_next;
    logic [7:0]  phase_cnt;
    logic [7:0]  phase_cnt_next;
    logic [15:0] timeout_cnt;
    logic [15:0] timeout_cnt_next;
    logic        reconfig;
    logic        reconfig_next;

    // ------------------------------------------------------------------------
    // State and counter registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state       <= S_IDLE;
            phase_cnt   <= 8'd0;
            timeout_cnt <= 16'd0;
            reconfig    <= 1'b0;
        end else begin
            state       <= state_next;
            phase_cnt   <= phase_cnt_next;
            timeout_cnt <= timeout_cnt_next;
            reconfig    <= reconfig_next;
        end
    end

    // ------------------------------------------------------------------------
    // Next-state logic. phase_cnt holds the remaining cycles of the current
    // timed phase; a phase ends on the cycle where it reads 1 (a value of 0
    // is treated the same way so an out-of-range parameter cannot stall).
    // ------------------------------------------------------------------------
    always_comb begin
        state_next       = state;
        phase_cnt_next   = phase_cnt;
        timeout_cnt_next = timeout_cnt;
        reconfig_next    = reconfig;

        case (state)
            S_IDLE: begin
                reconfig_next = 1'b0;
                if (start_i || AUTO) begin
                    state_next     = S_CFG_RST;
                    phase_cnt_next = RESET_LEN;
                end
            end

            S_CFG_RST: begin
                if (phase_cnt <= 8'd1) begin
                    state_next       = S_CFG_RUN;
                    phase_cnt_next   = 8'd0;
                    timeout_cnt_next = 16'd0;
                end else begin
                    phase_cnt_next = phase_cnt - 8'd1;
                end
            end

            S_CFG_RUN: begin
                // timeout_cnt counts completed CFG_RUN cycles; the check uses
                // the incremented value so ERROR follows exactly CFG_TIMEOUT
                // cycles. A done in that same cycle takes priority.
                timeout_cnt_next = timeout_cnt + 16'd1;
                if (configurator_done_i) begin
                    state_next     = S_CFG_DRAIN;
                    phase_cnt_next = DRAIN_LEN;
                end else if ((TIMEOUT_LEN != 16'd0) &&
                             (timeout_cnt_next == TIMEOUT_LEN)) begin
                    state_next    = S_ERROR;
                    reconfig_next = 1'b0;
                end
            end

            S_CFG_DRAIN: begin
                if (phase_cnt <= 8'd1) begin
                    state_next     = S_CGRA_RST;
                    phase_cnt_next = RESET_LEN;
                end else begin
                    phase_cnt_next = phase_cnt - 8'd1;
                end
            end

            S_CGRA_RST: begin
                if (phase_cnt <= 8'd1) begin
                    state_next     = S_RUN;
                    phase_cnt_next = 8'd0;
                    reconfig_next  = 1'b0;
                end else begin
                    phase_cnt_next = phase_cnt - 8'd1;
                end
            end

            S_RUN: begin
                if (reconfig_req_i) begin
                    state_next     = S_CFG_RST;
                    phase_cnt_next = RESET_LEN;
                    reconfig_next  = 1'b1;
                end
            end

            S_ERROR: begin
                if (clear_i) begin
                    state_next = S_IDLE;
                end
            end

            default: begin
                state_next    = S_IDLE;
                reconfig_next = 1'b0;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Moore output decode (state register and reconfig flag only).
    // During a reconfiguration the core is kept out of reset but disabled;
    // the CGRA stays in reset until its own reset phase has elapsed.
    // ------------------------------------------------------------------------
    always_comb begin
        config_clock_en_o     = 1'b0;
        config_reset_o        = 1'b0;
        configurator_reset_o  = 1'b0;
        configurator_enable_o = 1'b0;
        cgra_clock_en_o       = 1'b0;
        cgra_reset_o          = 1'b1;
        core_rst_no           = 1'b0;
        riscv_enable_o        = 1'b0;
        busy_o                = 1'b0;
        done_o                = 1'b0;
        error_o               = 1'b0;

        case (state)
            S_IDLE: begin
                config_reset_o       = 1'b1;
                configurator_reset_o = 1'b1;
            end

            S_CFG_RST: begin
                config_clock_en_o    = 1'b1;
                config_reset_o       = 1'b1;
                configurator_reset_o = 1'b1;
                core_rst_no          = reconfig;
                busy_o               = 1'b1;
            end

            S_CFG_RUN: begin
                config_clock_en_o     = 1'b1;
                configurator_enable_o = 1'b1;
                core_rst_no           = reconfig;
                busy_o                = 1'b1;
            end

            S_CFG_DRAIN: begin
                core_rst_no = reconfig;
                busy_o      = 1'b1;
            end

            S_CGRA_RST: begin
                cgra_clock_en_o = 1'b1;
                core_rst_no     = reconfig;
                busy_o          = 1'b1;
            end

            S_RUN: begin
                cgra_clock_en_o = 1'b1;
                cgra_reset_o    = 1'b0;
                core_rst_no     = 1'b1;
                riscv_enable_o  = 1'b1;
                done_o          = 1'b1;
            end

            S_ERROR: begin
                config_reset_o       = 1'b1;
                configurator_reset_o = 1'b1;
                error_o              = 1'b1;
            end

            default: begin
                config_reset_o       = 1'b1;
                configurator_reset_o = 1'b1;
            end
        endcase
    end

    assign state_o = state;

endmodule
`default_nettype wire

// File: tb/tb_cgra_boot_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_cgra_boot_sequencer
// Description : Self-checking bench for cgra_boot_sequencer. A directed
//               vector table covers a nominal boot and a reconfiguration;
//               hand-written sequences cover timeout, done-on-timeout-cycle,
//               mid-sequence reset and AUTO_START; a random phase is checked
//               cycle by cycle against a dwell-time reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cgra_boot_sequencer;

    localparam int RST_LEN   = 2;
    localparam int DRN_LEN   = 1;
    localparam int TO_LEN    = 10;
    localparam int AUTO_MAIN = 0;

    // Output bundle order:
    // {cfg_clk_en, cfg_rst, cfgr_rst, cfgr_en, cgra_clk_en, cgra_rst,
    //  core_rst_n, riscv_en, busy, done, error}
    localparam logic [10:0] O_IDLE    = 11'b01100100000;
    localparam logic [10:0] O_CRST_F  = 11'b11100100100;
    localparam logic [10:0] O_CRST_R  = 11'b11100110100;
    localparam logic [10:0] O_CRUN_F  = 11'b10010100100;
    localparam logic [10:0] O_CRUN_R  = 11'b10010110100;
    localparam logic [10:0] O_DRAIN_F = 11'b00000100100;
    localparam logic [10:0] O_DRAIN_R = 11'b00000110100;
    localparam logic [10:0] O_GRST_F  = 11'b00001100100;
    localparam logic [10:0] O_GRST_R  = 11'b00001110100;
    localparam logic [10:0] O_RUN     = 11'b00001011010;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n, start, reconfig_req, clear, cfg_done;
    logic cfg_clk_en, cfg_rst, cfgr_rst, cfgr_en, cgra_clk_en, cgra_rst;
    logic core_rst_n, riscv_en, busy, done, error;
    logic [2:0] state;
    logic [10:0] outs;

    assign outs = {cfg_clk_en, cfg_rst, cfgr_rst, cfgr_en, cgra_clk_en,
                   cgra_rst, core_rst_n, riscv_en, busy, done, error};

    cgra_boot_sequencer #(
        .RESET_CYCLES(RST_LEN),
        .DRAIN_CYCLES(DRN_LEN),
        .CFG_TIMEOUT (TO_LEN),
        .AUTO_START  (AUTO_MAIN)
    ) dut (
        .clk_i                (clk),
        .rst_ni               (rst_n),
        .start_i              (start),
        .reconfig_req_i       (reconfig_req),
        .clear_i              (clear),
        .configurator_done_i  (cfg_done),
        .config_clock_en_o    (cfg_clk_en),
        .config_reset_o       (cfg_rst),
        .configurator_reset_o (cfgr_rst),
        .configurator_enable_o(cfgr_en),
        .cgra_clock_en_o      (cgra_clk_en),
        .cgra_reset_o         (cgra_rst),
        .core_rst_no          (core_rst_n),
        .riscv_enable_o       (riscv_en),
        .busy_o               (busy),
        .done_o               (done),
        .error_o              (error),
        .state_o              (state)
    );

    // Second instance: auto start, timeout disabled.
    logic a_rst_n, a_done, a_zero;
    logic a_cce, a_cr, a_cfr, a_cfe, a_gce, a_gr, a_crn, a_re, a_busy, a_dn, a_err;
    logic [2:0] a_state;

    cgra_boot_sequencer #(
        .RESET_CYCLES(RST_LEN),
        .DRAIN_CYCLES(DRN_LEN),
        .CFG_TIMEOUT (0),
        .AUTO_START  (1)
    ) dut_auto (
        .clk_i                (clk),
        .rst_ni               (a_rst_n),
        .start_i              (a_zero),
        .reconfig_req_i       (a_zero),
        .clear_i              (a_zero),
        .configurator_done_i  (a_done),
        .config_clock_en_o    (a_cce),
        .config_reset_o       (a_cr),
        .configurator_reset_o (a_cfr),
        .configurator_enable_o(a_cfe),
        .cgra_clock_en_o      (a_gce),
        .cgra_reset_o         (a_gr),
        .core_rst_no          (a_crn),
        .riscv_enable_o       (a_re),
        .busy_o               (a_busy),
        .done_o               (a_dn),
        .error_o              (a_err),
        .state_o              (a_state)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // ------------------------------------------------------------------------
    // Reference model: current state plus cycles already spent in it.
    // ------------------------------------------------------------------------
    int m_state = 0;
    int m_dwell = 0;
    bit m_rc    = 1'b0;

    function automatic logic [10:0] model_out(input int s, input bit rc);
        logic cce, cr, cfr, cfe, gce, gr, crn, re, b, d, e;
        bit in_seq;
        in_seq = (s >= 1) && (s <= 4);
        cce = (s == 1) || (s == 2);
        cr  = (s == 0) || (s == 1) || (s == 6);
        cfr = cr;
        cfe = (s == 2);
        gce = (s == 4) || (s == 5);
        gr  = (s != 5);
        crn = (s == 5) || (rc && in_seq);
        re  = (s == 5);
        b   = in_seq;
        d   = (s == 5);
        e   = (s == 6);
        return {cce, cr, cfr, cfe, gce, gr, crn, re, b, d, e};
    endfunction

    task automatic model_clock(input logic rn, st, rq, cl, dn);
        int nxt;
        if (!rn) begin
            m_state = 0;
            m_dwell = 0;
            m_rc    = 1'b0;
        end else begin
            nxt = m_state;
            case (m_state)
                0: if (st || (AUTO_MAIN != 0)) nxt = 1;
                1: if (m_dwell + 1 >= RST_LEN) nxt = 2;
                2: begin
                    if (dn) nxt = 3;
                    else if ((TO_LEN != 0) && (m_dwell + 1 >= TO_LEN)) nxt = 6;
                end
                3: if (m_dwell + 1 >= DRN_LEN) nxt = 4;
                4: if (m_dwell + 1 >= RST_LEN) nxt = 5;
                5: if (rq) nxt = 1;
                6: if (cl) nxt = 0;
                default: nxt = 0;
            endcase
            if (m_state == 5 && nxt == 1) m_rc = 1'b1;
            if (nxt == 5 || nxt == 0 || nxt == 6) m_rc = 1'b0;
            m_dwell = (nxt != m_state) ? 0 : m_dwell + 1;
            m_state = nxt;
        end
    endtask

    task automatic check(input string name, input logic [13:0] got, input logic [13:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: state/outputs got %h, expected %h (t=%0t)", name, got, exp, $time);
        end
    endtask

    task automatic check_bit(input string name, input logic got, input logic exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b, expected %b (t=%0t)", name, got, exp, $time);
        end
    endtask

    // Apply one cycle of inputs, advance the model, compare after the edge.
    task automatic step(input logic rn, st, rq, cl, dn);
        rst_n        = rn;
        start        = st;
        reconfig_req = rq;
        clear        = cl;
        cfg_done     = dn;
        @(posedge clk);
        model_clock(rn, st, rq, cl, dn);
        #1;
        check("model", {state, outs}, {3'(m_state), model_out(m_state, m_rc)});
        check_bit("clk_exclusive", cfg_clk_en & cgra_clk_en, 1'b0);
    endtask

    typedef struct {
        logic       st;
        logic       rq;
        logic       cl;
        logic       dn;
        logic [2:0] exp_state;
        logic [10:0] exp_out;
    } vec_t;

    vec_t vecs[19];

    function automatic vec_t mk(input logic st, rq, cl, dn, input logic [2:0] es,
                                input logic [10:0] eo);
        vec_t v;
        v.st = st; v.rq = rq; v.cl = cl; v.dn = dn;
        v.exp_state = es; v.exp_out = eo;
        return v;
    endfunction

    initial begin
        // Nominal boot (reconfig/clear in IDLE and done in CFG_RST are ignored)
        vecs[0]  = mk(1, 1, 1, 0, 3'd1, O_CRST_F);
        vecs[1]  = mk(0, 0, 0, 1, 3'd1, O_CRST_F);
        vecs[2]  = mk(0, 0, 0, 0, 3'd2, O_CRUN_F);
        vecs[3]  = mk(0, 0, 0, 0, 3'd2, O_CRUN_F);
        vecs[4]  = mk(0, 0, 0, 0, 3'd2, O_CRUN_F);
        vecs[5]  = mk(0, 0, 0, 0, 3'd2, O_CRUN_F);
        vecs[6]  = mk(0, 0, 0, 0, 3'd2, O_CRUN_F);
        vecs[7]  = mk(0, 0, 0, 1, 3'd3, O_DRAIN_F);
        vecs[8]  = mk(0, 0, 0, 0, 3'd4, O_GRST_F);
        vecs[9]  = mk(0, 0, 0, 0, 3'd4, O_GRST_F);
        vecs[10] = mk(0, 0, 0, 0, 3'd5, O_RUN);
        // Reconfiguration: core stays out of reset throughout
        vecs[11] = mk(0, 1, 0, 0, 3'd1, O_CRST_R);
        vecs[12] = mk(0, 0, 0, 0, 3'd1, O_CRST_R);
        vecs[13] = mk(0, 0, 0, 0, 3'd2, O_CRUN_R);
        vecs[14] = mk(0, 0, 0, 1, 3'd3, O_DRAIN_R);
        vecs[15] = mk(0, 0, 0, 0, 3'd4, O_GRST_R);
        vecs[16] = mk(0, 0, 0, 0, 3'd4, O_GRST_R);
        vecs[17] = mk(0, 0, 0, 0, 3'd5, O_RUN);
        // start/clear in RUN are ignored
        vecs[18] = mk(1, 0, 1, 1, 3'd5, O_RUN);

        a_zero  = 1'b0;
        a_done  = 1'b0;
        a_rst_n = 1'b0;

        // ---------------- reset ----------------
        step(0, 0, 0, 0, 0);
        step(0, 1, 0, 0, 1);
        check("reset_state", {state, outs}, {3'd0, O_IDLE});

        // ---------------- AUTO_START / timeout disabled ----------------
        a_rst_n = 1'b1;
        step(1, 0, 0, 0, 0);
        check_bit("auto_first_edge", a_state == 3'd1, 1'b1);
        step(1, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0);
        check_bit("auto_cfg_run", a_state == 3'd2, 1'b1);
        for (int i = 0; i < 25; i++) step(1, 0, 0, 0, 0);
        check_bit("auto_no_timeout", a_state == 3'd2, 1'b1);
        a_done = 1'b1;
        step(1, 0, 0, 0, 0);
        a_done = 1'b0;
        check_bit("auto_done", a_state == 3'd3, 1'b1);
        check_bit("idle_stays_idle", state == 3'd0, 1'b1);

        // ---------------- vector table ----------------
        for (int i = 0; i < 19; i++) begin
            step(1, vecs[i].st, vecs[i].rq, vecs[i].cl, vecs[i].dn);
            check($sformatf("table[%0d]", i), {state, outs},
                  {vecs[i].exp_state, vecs[i].exp_out});
        end

        // ---------------- timeout ----------------
        step(0, 0, 0, 0, 0);
        step(1, 1, 0, 0, 0);
        step(1, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0);              // CFG_RUN cycle 1
        for (int i = 0; i < 9; i++) step(1, 0, 0, 0, 0);
        check_bit("to_cycle10_still_run", state == 3'd2, 1'b1);
        step(1, 0, 0, 0, 0);
        check("timeout_error", {state, outs}, {3'd6, O_IDLE | 11'b1});
        step(1, 1, 1, 0, 1);              // start/reconfig/done ignored in ERROR
        check_bit("error_holds", state == 3'd6, 1'b1);
        step(1, 0, 0, 1, 0);
        check("clear_to_idle", {state, outs}, {3'd0, O_IDLE});
        step(1, 1, 0, 0, 0);
        step(1, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0);
        step(1, 0, 0, 0, 1);
        step(1, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0);
        check("reboot_after_clear", {state, outs}, {3'd5, O_RUN});

        // ---------------- done on the timeout cycle ----------------
        step(0, 0, 0, 0, 0);
        step(1, 1, 0, 0, 0);
        step(1, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0);              // CFG_RUN cycle 1
        for (int i = 0; i < 9; i++) step(1, 0, 0, 0, 0);
        step(1, 0, 0, 0, 1);
        check("done_wins", {state, outs}, {3'd3, O_DRAIN_F});

        // ---------------- reset mid CFG_RUN, stale done ----------------
        step(0, 0, 0, 0, 0);
        step(1, 1, 0, 0, 0);
        step(1, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0);
        check_bit("pre_reset_in_cfg_run", state == 3'd2, 1'b1);
        step(0, 0, 0, 0, 0);
        check("mid_reset", {state, outs}, {3'd0, O_IDLE});
        for (int i = 0; i < 3; i++) step(1, 0, 0, 0, 1);
        check("stale_done_ignored", {state, outs}, {3'd0, O_IDLE});

        // ---------------- randomized ----------------
        for (int i = 0; i < 600; i++) begin
            step(logic'($urandom_range(0, 59) != 0),
                 logic'($urandom_range(0, 2) == 0),
                 logic'($urandom_range(0, 7) == 0),
                 logic'($urandom_range(0, 2) == 0),
                 logic'($urandom_range(0, 4) == 0));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/cgra_boot_sequencer.md
CGRA_BOOT_SEQUENCER -- requirements
Module: cgra_boot_sequencer

Interface
REQ-001 Parameter RESET_CYCLES, default 2: number of cycles each reset phase is held; legal range 1..255.
REQ-002 Parameter DRAIN_CYCLES, default 1: number of idle cycles between configurator disable and CGRA reset phase; legal range 1..255.
REQ-003 Parameter CFG_TIMEOUT, default 1000: maximum number of CFG_RUN cycles before the block declares an error; 16-bit; the value 0 disables the timeout.
REQ-004 Parameter AUTO_START, default 0: when 1, IDLE behaves as if start_i=1.
REQ-005 clk_i  in  1  single clock, rising edge.
REQ-006 rst_ni  in  1  reset, synchronous, active-low.
REQ-007 start_i  in  1  request to run the boot sequence; sampled in IDLE only.
REQ-008 reconfig_req_i  in  1  request to reconfigure the CGRA; sampled in RUN only.
REQ-009 clear_i  in  1  leave ERROR; sampled in ERROR only.
REQ-010 configurator_done_i  in  1  configurator has finished loading the bitstream.
REQ-011 config_clock_en_o  out  1  configuration clock enable.
REQ-012 config_reset_o  out  1  configuration chain reset, active-high.
REQ-013 configurator_reset_o  out  1  configurator reset, active-high.
REQ-014 configurator_enable_o  out  1  configurator run enable.
REQ-015 cgra_clock_en_o  out  1  CGRA datapath clock enable.
REQ-016 cgra_reset_o  out  1  CGRA datapath reset, active-high.
REQ-017 core_rst_no  out  1  RISC-V core reset, active-low.
REQ-018 riscv_enable_o  out  1  RISC-V core run enable.
REQ-019 busy_o / done_o / error_o  out  1 each  status flags: sequence in progress / in RUN / in ERROR.
REQ-020 state_o  out  3  encoded FSM state: IDLE=0, CFG_RST=1, CFG_RUN=2, CFG_DRAIN=3, CGRA_RST=4, RUN=5, ERROR=6.

Function
REQ-021 The block SHALL be a Moore FSM; all outputs SHALL be decoded only from the state register and SHALL change in the same cycle that the state changes.
REQ-022 IDLE outputs: config_reset_o=1, configurator_reset_o=1, cgra_reset_o=1, core_rst_no=0; all other outputs=0.
REQ-023 IDLE -> CFG_RST when start_i=1 (or AUTO_START=1) is sampled; the phase counter loads RESET_CYCLES on this transition.
REQ-024 CFG_RST: outputs as IDLE plus config_clock_en_o=1 and busy_o=1; after exactly RESET_CYCLES cycles -> CFG_RUN.
REQ-025 CFG_RUN: config_clock_en_o=1, configurator_enable_o=1, config_reset_o=0, configurator_reset_o=0, busy_o=1; the timeout counter starts from 0 on entry and increments once per cycle.
REQ-026 CFG_RUN -> CFG_DRAIN when configurator_done_i=1 is sampled.
REQ-027 CFG_RUN -> ERROR when CFG_TIMEOUT!=0 and the counter reaches CFG_TIMEOUT with done low; done and timeout in the same cycle: done wins.
REQ-028 CFG_DRAIN: config_clock_en_o=0, configurator_enable_o=0, resets deasserted, busy_o=1; after DRAIN_CYCLES cycles -> CGRA_RST.
REQ-029 CGRA_RST: cgra_clock_en_o=1, cgra_reset_o=1, riscv_enable_o=0, busy_o=1; after RESET_CYCLES cycles -> RUN.
REQ-030 Coming from a first boot, core_rst_no SHALL stay 0 in CGRA_RST; coming from a reconfiguration, it SHALL stay 1.
REQ-031 RUN: cgra_clock_en_o=1, cgra_reset_o=0, core_rst_no=1, riscv_enable_o=1, done_o=1, busy_o=0.
REQ-032 RUN -> CFG_RST when reconfig_req_i=1 is sampled.
REQ-033 During a reconfiguration (CFG_RST through CGRA_RST), core_rst_no SHALL stay 1 and riscv_enable_o SHALL be 0; a sticky reconfig flag records this and is cleared on entry to RUN.
REQ-034 ERROR: outputs as IDLE except error_o=1; -> IDLE when clear_i=1 is sampled.
REQ-035 start_i, reconfig_req_i and clear_i SHALL be ignored outside their sampling state.
REQ-036 configurator_done_i SHALL be ignored outside CFG_RUN.
REQ-037 config_clock_en_o and cgra_clock_en_o SHALL never both be 1 in the same cycle.

Reset
REQ-038 rst_ni=0 sampled at any edge, including mid-sequence, SHALL force IDLE, clear the phase counter, timeout counter and reconfig flag, and drive the IDLE output values of REQ-022 from the next cycle on.
REQ-039 With AUTO_START=1, the block SHALL enter CFG_RST on the first edge after rst_ni returns to 1.

Verification
REQ-040 Nominal boot: start_i pulsed; done raised 5 cycles into CFG_RUN -> config_reset_o high exactly 2 cycles; config_clock_en_o drops 1 cycle after done is sampled (edge E); riscv_enable_o and core_rst_no rise at E+3; done_o=1.
REQ-041 Timeout: CFG_TIMEOUT=10, done never asserted -> ERROR after exactly 10 CFG_RUN cycles with error_o=1; clear_i returns the block to IDLE; the following start_i boots normally.
REQ-042 Done on the timeout cycle: done asserted in CFG_RUN cycle 10 with CFG_TIMEOUT=10 -> CFG_DRAIN, no error.
REQ-043 Reconfiguration: reconfig_req_i in RUN -> riscv_enable_o=0 next cycle; core_rst_no stays 1 throughout; RUN re-entered after the same phase lengths.
REQ-044 Reset mid-CFG_RUN: rst_ni=0 for 1 cycle -> state_o=0 and all outputs at reset values; a stale configurator_done_i is ignored in IDLE.
REQ-045 Clock exclusivity: on every cycle of all scenarios, assert that config_clock_en_o and cgra_clock_en_o are not both 1.
